// File: rtl/axi_mem_slave.sv
`default_nettype none
// ============================================================================
// Module   : axi_mem_slave
// Purpose  : AXI4 responder backing the match/action table memory. Serves a
//            single master with 32-bit data, FIXED/INCR bursts (WRAP when
//            AXI_MEM_WRAP_EN is defined), byte strobes and a word-addressed
//            array. Write and read channels run independent FSMs and may be
//            active in the same cycle.
// Ports    : clk, rst (async, active-low)
//            AW/W/B : write address, write data, write response channels
//            AR/R   : read address and read data channels
//            *lock/*cache/*prot/*qos are accepted and ignored.
// Config   : AXI_MEM_WRAP_EN - accept WRAP bursts with len in {1,3,7,15}.
// Revision : 1.0 - initial release
// ============================================================================
module axi_mem_slave #(
    parameter int          ID_WIDTH   = 4,
    parameter int          DEPTH_LOG2 = 14,
    parameter logic [31:0] BASE_ADDR  = 32'h0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ID_WIDTH-1:0] axi_awid,
    input  logic [31:0]         axi_awaddr,
    input  logic [7:0]          axi_awlen,
    input  logic [2:0]          axi_awsize,
    input  logic [1:0]          axi_awburst,
    input  logic                axi_awlock,
    input  logic [3:0]          axi_awcache,
    input  logic [2:0]          axi_awprot,
    input  logic [3:0]          axi_awqos,
    input  logic                axi_awvalid,
    output logic                axi_awready,
    input  logic [31:0]         axi_wdata,
    input  logic [3:0]          axi_wstrb,
    input  logic                axi_wlast,
    input  logic                axi_wvalid,
    output logic                axi_wready,
    output logic [ID_WIDTH-1:0] axi_bid,
    output logic [1:0]          axi_bresp,
    output logic                axi_bvalid,
    input  logic                axi_bready,
    input  logic [ID_WIDTH-1:0] axi_arid,
    input  logic [31:0]         axi_araddr,
    input  logic [7:0]          axi_arlen,
    input  logic [2:0]          axi_arsize,
    input  logic [1:0]          axi_arburst,
    input  logic                axi_arlock,
    input  logic [3:0]          axi_arcache,
    input  logic [2:0]          axi_arprot,
    input  logic [3:0]          axi_arqos,
    input  logic                axi_arvalid,
    output logic                axi_arready,
    output logic [ID_WIDTH-1:0] axi_rid,
    output logic [31:0]         axi_rdata,
    output logic [1:0]          axi_rresp,
    output logic                axi_rlast,
    output logic                axi_rvalid,
    input  logic                axi_rready
);

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
    typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

    logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];

    function automatic logic burst_legal(input logic [2:0] size, input logic [1:0] burst,
                                         input logic wrap_ok);
        logic ok;
        ok = (size <= 3'd2);
        if (burst == 2'b11) ok = 1'b0;
        if (burst == 2'b10 && !wrap_ok) ok = 1'b0;
        return ok;
    endfunction

    // WRAP keeps the upper address bits and wraps the low bits inside mask;
    // with a zero mask it degenerates to FIXED.
    function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [2:0] size,
                                              input logic [1:0] burst, input logic [31:0] mask);
        logic [31:0] step;
        logic [31:0] res;
        step = addr + (32'd1 << size);
        case (burst)
            2'b01:   res = step;
            2'b10:   res = (addr & ~mask) | (step & mask);
            default: res = addr;
        endcase
        return res;
    endfunction

    // ---------------- write channel state ----------------
    w_state_t            wst_q, wst_d;
    logic                awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic [1:0]          bresp_q, bresp_d;
    logic [ID_WIDTH-1:0] wid_q, wid_d;
    logic [31:0]         waddr_q, waddr_d;
    logic [7:0]          wlen_q, wlen_d, wcnt_q, wcnt_d;
    logic [2:0]          wsize_q, wsize_d;
    logic [1:0]          wburst_q, wburst_d;
    logic                will_q, will_d, wlerr_q, wlerr_d, wdec_q, wdec_d;
    logic                mem_we, w_is_last;

    // ---------------- read channel state ----------------
    r_state_t            rdst_q, rdst_d;
    logic                arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic [1:0]          rresp_q, rresp_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [ID_WIDTH-1:0] rid_q, rid_d;
    logic [31:0]         raddr_q, raddr_d;
    logic [7:0]          rlen_q, rlen_d, rcnt_q, rcnt_d;
    logic [2:0]          rsize_q, rsize_d;
    logic [1:0]          rburst_q, rburst_d;
    logic                rill_q, rill_d;

    // ---------------- address decode ----------------
    logic [31:0]           wr_off, rd_off, wmask, rmask, rd_word;
    logic                  wr_in, rd_in, aw_wrap_ok, ar_wrap_ok;
    logic [DEPTH_LOG2-1:0] wr_idx, rd_idx;

    assign wr_off  = waddr_q - BASE_ADDR;
    assign rd_off  = raddr_q - BASE_ADDR;
    assign wr_in   = (wr_off >> (DEPTH_LOG2 + 2)) == 32'd0;
    assign rd_in   = (rd_off >> (DEPTH_LOG2 + 2)) == 32'd0;
    assign wr_idx  = wr_off[DEPTH_LOG2+1:2];
    assign rd_idx  = rd_off[DEPTH_LOG2+1:2];
    assign rd_word = mem[rd_idx];

`ifdef AXI_MEM_WRAP_EN
    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction
    assign aw_wrap_ok = wrap_len_ok(axi_awlen);
    assign ar_wrap_ok = wrap_len_ok(axi_arlen);
    // Wrap block is (len+1)<<size bytes, aligned to its own size.
    assign wmask = (({24'd0, wlen_q} + 32'd1) << wsize_q) - 32'd1;
    assign rmask = (({24'd0, rlen_q} + 32'd1) << rsize_q) - 32'd1;
`else
    assign aw_wrap_ok = 1'b0;
    assign ar_wrap_ok = 1'b0;
    assign wmask      = 32'd0;
    assign rmask      = 32'd0;
`endif

    // ---------------- write FSM ----------------
    always_comb begin
        wst_d = wst_q;  awready_d = awready_q;  wready_d = wready_q;
        bvalid_d = bvalid_q;  bresp_d = bresp_q;  wid_d = wid_q;
        waddr_d = waddr_q;  wlen_d = wlen_q;  wcnt_d = wcnt_q;
        wsize_d = wsize_q;  wburst_d = wburst_q;
        will_d = will_q;  wlerr_d = wlerr_q;  wdec_d = wdec_q;
        mem_we = 1'b0;
        w_is_last = (wcnt_q == wlen_q);
        case (wst_q)
            W_IDLE: begin
                awready_d = 1'b1;
                if (axi_awvalid && awready_q) begin
                    wid_d = axi_awid;  waddr_d = axi_awaddr;  wlen_d = axi_awlen;
                    wsize_d = axi_awsize;  wburst_d = axi_awburst;  wcnt_d = 8'd0;
                    will_d = !burst_legal(axi_awsize, axi_awburst, aw_wrap_ok);
                    wlerr_d = 1'b0;  wdec_d = 1'b0;
                    awready_d = 1'b0;  wready_d = 1'b1;  wst_d = W_DATA;
                end
            end
            W_DATA: begin
                if (axi_wvalid && wready_q) begin
                    mem_we = !will_q && wr_in;
                    // wlast mismatch is only reported; beat count follows awlen.
                    if (axi_wlast != w_is_last) wlerr_d = 1'b1;
                    if (!wr_in) wdec_d = 1'b1;
                    waddr_d = next_addr(waddr_q, wsize_q, wburst_q, wmask);
                    wcnt_d  = wcnt_q + 8'd1;
                    if (w_is_last) begin
                        wready_d = 1'b0;  bvalid_d = 1'b1;  wst_d = W_RESP;
                        bresp_d = (will_q || wlerr_d) ? 2'b10 : (wdec_d ? 2'b11 : 2'b00);
                    end
                end
            end
            default: begin
                if (axi_bready) begin
                    bvalid_d = 1'b0;  awready_d = 1'b1;  wst_d = W_IDLE;
                end
            end
        endcase
    end

    // ---------------- read FSM ----------------
    always_comb begin
        rdst_d = rdst_q;  arready_d = arready_q;  rvalid_d = rvalid_q;  rlast_d = rlast_q;
        rresp_d = rresp_q;  rdata_d = rdata_q;  rid_d = rid_q;  raddr_d = raddr_q;
        rlen_d = rlen_q;  rcnt_d = rcnt_q;  rsize_d = rsize_q;  rburst_d = rburst_q;
        rill_d = rill_q;
        case (rdst_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (axi_arvalid && arready_q) begin
                    rid_d = axi_arid;  raddr_d = axi_araddr;  rlen_d = axi_arlen;
                    rsize_d = axi_arsize;  rburst_d = axi_arburst;  rcnt_d = 8'd0;
                    rill_d = !burst_legal(axi_arsize, axi_arburst, ar_wrap_ok);
                    arready_d = 1'b0;  rdst_d = R_DATA;
                end
            end
            default: begin
                // Fetch the first beat, or the next one whenever the current
                // beat is being accepted; otherwise the outputs hold.
                if (!rvalid_q || axi_rready) begin
                    if (rvalid_q && rlast_q) begin
                        rvalid_d = 1'b0;  rlast_d = 1'b0;  arready_d = 1'b1;  rdst_d = R_IDLE;
                    end else begin
                        rvalid_d = 1'b1;
                        rdata_d  = (!rill_q && rd_in) ? rd_word : 32'd0;
                        rresp_d  = rill_q ? 2'b10 : (rd_in ? 2'b00 : 2'b11);
                        rlast_d  = (rcnt_q == rlen_q);
                        raddr_d  = next_addr(raddr_q, rsize_q, rburst_q, rmask);
                        rcnt_d   = rcnt_q + 8'd1;
                    end
                end
            end
        endcase
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wst_q <= W_IDLE;  awready_q <= 1'b0;  wready_q <= 1'b0;  bvalid_q <= 1'b0;
            bresp_q <= 2'b00;  wid_q <= '0;  waddr_q <= 32'd0;  wlen_q <= 8'd0;
            wcnt_q <= 8'd0;  wsize_q <= 3'd0;  wburst_q <= 2'b00;
            will_q <= 1'b0;  wlerr_q <= 1'b0;  wdec_q <= 1'b0;
            rdst_q <= R_IDLE;  arready_q <= 1'b0;  rvalid_q <= 1'b0;  rlast_q <= 1'b0;
            rresp_q <= 2'b00;  rdata_q <= 32'd0;  rid_q <= '0;  raddr_q <= 32'd0;
            rlen_q <= 8'd0;  rcnt_q <= 8'd0;  rsize_q <= 3'd0;  rburst_q <= 2'b00;
            rill_q <= 1'b0;
        end else begin
            wst_q <= wst_d;  awready_q <= awready_d;  wready_q <= wready_d;  bvalid_q <= bvalid_d;
            bresp_q <= bresp_d;  wid_q <= wid_d;  waddr_q <= waddr_d;  wlen_q <= wlen_d;
            wcnt_q <= wcnt_d;  wsize_q <= wsize_d;  wburst_q <= wburst_d;
            will_q <= will_d;  wlerr_q <= wlerr_d;  wdec_q <= wdec_d;
            rdst_q <= rdst_d;  arready_q <= arready_d;  rvalid_q <= rvalid_d;  rlast_q <= rlast_d;
            rresp_q <= rresp_d;  rdata_q <= rdata_d;  rid_q <= rid_d;  raddr_q <= raddr_d;
            rlen_q <= rlen_d;  rcnt_q <= rcnt_d;  rsize_q <= rsize_d;  rburst_q <= rburst_d;
            rill_q <= rill_d;
        end
    end

    // Storage is never reset. A read fetch in the same edge as a write sees
    // the old word because both use the pre-edge array contents.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (axi_wstrb[b]) mem[wr_idx][8*b +: 8] <= axi_wdata[8*b +: 8];
            end
        end
    end

    assign axi_awready = awready_q;
    assign axi_wready  = wready_q;
    assign axi_bvalid  = bvalid_q;
    assign axi_bresp   = bresp_q;
    assign axi_bid     = wid_q;
    assign axi_arready = arready_q;
    assign axi_rvalid  = rvalid_q;
    assign axi_rdata   = rdata_q;
    assign axi_rresp   = rresp_q;
    assign axi_rlast   = rlast_q;
    assign axi_rid     = rid_q;

    logic unused_ok;
    assign unused_ok = ^{axi_awlock, axi_awcache, axi_awprot, axi_awqos,
                         axi_arlock, axi_arcache, axi_arprot, axi_arqos,
                         wr_off[1:0], rd_off[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_axi_mem_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_mem_slave
// Purpose  : Self-checking bench for axi_mem_slave: single-beat vector table
//            plus hand-written burst, boundary, wrap, reset and overlap cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_mem_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  axi_awid, axi_arid, axi_bid, axi_rid;
    logic [31:0] axi_awaddr, axi_araddr, axi_wdata, axi_rdata;
    logic [7:0]  axi_awlen, axi_arlen;
    logic [2:0]  axi_awsize, axi_arsize;
    logic [1:0]  axi_awburst, axi_arburst, axi_bresp, axi_rresp;
    logic [3:0]  axi_wstrb;
    logic        axi_awvalid, axi_awready, axi_wlast, axi_wvalid, axi_wready;
    logic        axi_bvalid, axi_bready, axi_arvalid, axi_arready;
    logic        axi_rlast, axi_rvalid, axi_rready;

    always #5 clk = ~clk;

    axi_mem_slave #(.ID_WIDTH(4), .DEPTH_LOG2(14), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .rst(rst),
        .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
        .axi_awsize(axi_awsize), .axi_awburst(axi_awburst),
        .axi_awlock(1'b0), .axi_awcache(4'd0), .axi_awprot(3'd0), .axi_awqos(4'd0),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
        .axi_arsize(axi_arsize), .axi_arburst(axi_arburst),
        .axi_arlock(1'b0), .axi_arcache(4'd0), .axi_arprot(3'd0), .axi_arqos(4'd0),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
    );

    int checks   = 0;
    int failures = 0;

    logic [31:0] wbuf    [16];
    logic [31:0] rd_data [16];
    logic [1:0]  rd_resp [16];
    logic        rd_last [16];
    logic [3:0]  rd_id;
    logic [1:0]  b_resp;
    logic [3:0]  b_id;

    typedef struct {
        logic [3:0]  wid;
        logic [3:0]  rid;
        logic [31:0] addr;
        logic        pre;
        logic [31:0] pre_data;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  exp_b;
        logic [31:0] exp_rd;
        logic [1:0]  exp_r;
    } vec_t;
    vec_t vt [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return axi_awready;
            1:       return axi_wready;
            2:       return axi_bvalid;
            3:       return axi_arready;
            default: return axi_rvalid;
        endcase
    endfunction

    // Called at a negedge; returns at the negedge where the signal is high.
    task automatic wait_hi(input int sel, input string name);
        int n;
        n = 0;
        while (!sig(sel) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!sig(sel)) begin
            checks++;
            failures++;
            $display("FAIL timeout %s: got 0 expected 1", name);
        end
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input logic [3:0] strb,
                            input int lastpos);
        axi_awid = id; axi_awaddr = addr; axi_awlen = len; axi_awsize = size;
        axi_awburst = burst; axi_awvalid = 1'b1;
        wait_hi(0, "awready");
        @(posedge clk); @(negedge clk);
        axi_awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            axi_wdata = wbuf[i]; axi_wstrb = strb; axi_wlast = (i == lastpos); axi_wvalid = 1'b1;
            wait_hi(1, "wready");
            @(posedge clk); @(negedge clk);
        end
        axi_wvalid = 1'b0; axi_wlast = 1'b0; axi_bready = 1'b1;
        wait_hi(2, "bvalid");
        b_resp = axi_bresp; b_id = axi_bid;
        @(posedge clk); @(negedge clk);
        axi_bready = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input int stall_at, input logic [31:0] stall_exp);
        axi_arid = id; axi_araddr = addr; axi_arlen = len; axi_arsize = size;
        axi_arburst = burst; axi_arvalid = 1'b1;
        wait_hi(3, "arready");
        @(posedge clk); @(negedge clk);
        axi_arvalid = 1'b0; axi_rready = 1'b1;
        for (int i = 0; i <= int'(len); i++) begin
            wait_hi(4, "rvalid");
            rd_data[i] = axi_rdata; rd_resp[i] = axi_rresp; rd_last[i] = axi_rlast; rd_id = axi_rid;
            if (i == stall_at) begin
                axi_rready = 1'b0;
                for (int k = 0; k < 2; k++) begin
                    @(posedge clk); @(negedge clk);
                    check("stall_rvalid", {31'd0, axi_rvalid}, 32'd1);
                    check("stall_rdata", axi_rdata, stall_exp);
                    check("stall_rlast", {31'd0, axi_rlast}, 32'd0);
                end
                axi_rready = 1'b1;
            end
            @(posedge clk); @(negedge clk);
        end
        axi_rready = 1'b0;
    endtask

    task automatic write1(input logic [31:0] addr, input logic [31:0] d);
        wbuf[0] = d;
        do_write(4'd0, addr, 8'd0, 3'd2, 2'b01, 4'hF, 0);
    endtask

    initial begin
        //        wid   rid   addr        pre   pre_data      data          strb    b      rdata         r
        vt[0] = '{4'd3, 4'd5, 32'h10,    1'b0, 32'h0,        32'hDEADBEEF, 4'hF, 2'b00, 32'hDEADBEEF, 2'b00};
        vt[1] = '{4'd1, 4'd2, 32'h0,     1'b1, 32'hFFFFFFFF, 32'h0000AAAA, 4'h3, 2'b00, 32'hFFFFAAAA, 2'b00};
        vt[2] = '{4'd7, 4'd8, 32'h44,    1'b1, 32'h12345678, 32'hAABBCCDD, 4'h8, 2'b00, 32'hAA345678, 2'b00};
        vt[3] = '{4'd9, 4'd6, 32'h10000, 1'b0, 32'h0,        32'hCAFEF00D, 4'hF, 2'b11, 32'h0,        2'b11};
        vt[4] = '{4'd2, 4'd4, 32'hFFFC,  1'b0, 32'h0,        32'h55AA55AA, 4'hF, 2'b00, 32'h55AA55AA, 2'b00};
        vt[5] = '{4'hF, 4'hE, 32'h20,    1'b1, 32'h11112222, 32'hFFFFFFFF, 4'h0, 2'b00, 32'h11112222, 2'b00};

        rst = 1'b0;
        axi_awid = '0; axi_awaddr = '0; axi_awlen = '0; axi_awsize = '0; axi_awburst = '0;
        axi_awvalid = 1'b0; axi_wdata = '0; axi_wstrb = '0; axi_wlast = 1'b0; axi_wvalid = 1'b0;
        axi_bready = 1'b0; axi_arid = '0; axi_araddr = '0; axi_arlen = '0; axi_arsize = '0;
        axi_arburst = '0; axi_arvalid = 1'b0; axi_rready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_outputs", {27'd0, axi_awready, axi_wready, axi_bvalid, axi_arready, axi_rvalid}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("awready_after_rst", {31'd0, axi_awready}, 32'd1);
        check("arready_after_rst", {31'd0, axi_arready}, 32'd1);

        // Single-beat table
        for (int v = 0; v < 6; v++) begin
            if (vt[v].pre) write1(vt[v].addr, vt[v].pre_data);
            wbuf[0] = vt[v].data;
            do_write(vt[v].wid, vt[v].addr, 8'd0, 3'd2, 2'b01, vt[v].strb, 0);
            check($sformatf("v%0d_bresp", v), {30'd0, b_resp}, {30'd0, vt[v].exp_b});
            check($sformatf("v%0d_bid", v), {28'd0, b_id}, {28'd0, vt[v].wid});
            do_read(vt[v].rid, vt[v].addr, 8'd0, 3'd2, 2'b01, -1, 32'd0);
            check($sformatf("v%0d_rdata", v), rd_data[0], vt[v].exp_rd);
            check($sformatf("v%0d_rresp", v), {30'd0, rd_resp[0]}, {30'd0, vt[v].exp_r});
            check($sformatf("v%0d_rlast", v), {31'd0, rd_last[0]}, 32'd1);
            check($sformatf("v%0d_rid", v), {28'd0, rd_id}, {28'd0, vt[v].rid});
        end
        // Out-of-window write must not alias onto word 0
        do_read(4'd0, 32'h0, 8'd0, 3'd2, 2'b01, -1, 32'd0);
        check("oow_no_alias", rd_data[0], 32'hFFFFAAAA);

        // INCR len=3, stall two cycles on beat index 2
        wbuf[0] = 32'd1; wbuf[1] = 32'd2; wbuf[2] = 32'd3; wbuf[3] = 32'd4;
        do_write(4'd1, 32'h100, 8'd3, 3'd2, 2'b01, 4'hF, 3);
        check("incr_bresp", {30'd0, b_resp}, 32'd0);
        do_read(4'd1, 32'h100, 8'd3, 3'd2, 2'b01, 2, 32'd3);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("incr_beat%0d", i), rd_data[i], 32'(i + 1));
            check($sformatf("incr_last%0d", i), {31'd0, rd_last[i]}, (i == 3) ? 32'd1 : 32'd0);
        end

        // FIXED len=2 at 0x20 leaves the last beat's data
        wbuf[0] = 32'd7; wbuf[1] = 32'd8; wbuf[2] = 32'd9;
        do_write(4'd2, 32'h20, 8'd2, 3'd2, 2'b00, 4'hF, 2);
        check("fixed_bresp", {30'd0, b_resp}, 32'd0);
        do_read(4'd2, 32'h20, 8'd0, 3'd2, 2'b01, -1, 32'd0);
        check("fixed_rdata", rd_data[0], 32'd9);

        // Burst crossing the window top: second beat DECERR and dropped
        wbuf[0] = 32'hA; wbuf[1] = 32'hB;
        do_write(4'd3, 32'hFFFC, 8'd1, 3'd2, 2'b01, 4'hF, 1);
        check("edge_bresp", {30'd0, b_resp}, 32'd3);
        do_read(4'd3, 32'hFFFC, 8'd1, 3'd2, 2'b01, -1, 32'd0);
        check("edge_b0_data", rd_data[0], 32'hA);
        check("edge_b0_resp", {30'd0, rd_resp[0]}, 32'd0);
        check("edge_b1_data", rd_data[1], 32'd0);
        check("edge_b1_resp", {30'd0, rd_resp[1]}, 32'd3);
        do_read(4'd0, 32'h0, 8'd0, 3'd2, 2'b01, -1, 32'd0);
        check("edge_no_alias", rd_data[0], 32'hFFFFAAAA);

        // WRAP len=3 at 0x108
        wbuf[0] = 32'h11; wbuf[1] = 32'h22; wbuf[2] = 32'h33; wbuf[3] = 32'h44;
        do_write(4'd4, 32'h108, 8'd3, 3'd2, 2'b10, 4'hF, 3);
        do_read(4'd4, 32'h100, 8'd3, 3'd2, 2'b01, -1, 32'd0);
`ifdef AXI_MEM_WRAP_EN
        check("wrap_bresp", {30'd0, b_resp}, 32'd0);
        check("wrap_w0", rd_data[0], 32'h33);
        check("wrap_w1", rd_data[1], 32'h44);
        check("wrap_w2", rd_data[2], 32'h11);
        check("wrap_w3", rd_data[3], 32'h22);
        do_read(4'd4, 32'h108, 8'd3, 3'd2, 2'b10, -1, 32'd0);
        check("wrap_r0", rd_data[0], 32'h11);
        check("wrap_r2", rd_data[2], 32'h33);
        check("wrap_r3_resp", {30'd0, rd_resp[3]}, 32'd0);
`else
        check("wrap_bresp", {30'd0, b_resp}, 32'd2);
        for (int i = 0; i < 4; i++)
            check($sformatf("wrap_unchanged%0d", i), rd_data[i], 32'(i + 1));
        do_read(4'd4, 32'h108, 8'd3, 3'd2, 2'b10, -1, 32'd0);
        check("wrap_rd_data", rd_data[0], 32'd0);
        check("wrap_rd_resp", {30'd0, rd_resp[0]}, 32'd2);
        check("wrap_rd_last", {31'd0, rd_last[3]}, 32'd1);
`endif

        // Illegal size: SLVERR and no write
        write1(32'h300, 32'h600DF00D);
        wbuf[0] = 32'hBAD0BAD0;
        do_write(4'd5, 32'h300, 8'd0, 3'd3, 2'b01, 4'hF, 0);
        check("size3_bresp", {30'd0, b_resp}, 32'd2);
        do_read(4'd5, 32'h300, 8'd0, 3'd2, 2'b01, -1, 32'd0);
        check("size3_unchanged", rd_data[0], 32'h600DF00D);

        // Early wlast: SLVERR, both beats still written
        wbuf[0] = 32'hA1; wbuf[1] = 32'hA2;
        do_write(4'd6, 32'h200, 8'd1, 3'd2, 2'b01, 4'hF, 0);
        check("early_last_bresp", {30'd0, b_resp}, 32'd2);
        do_read(4'd6, 32'h200, 8'd1, 3'd2, 2'b01, -1, 32'd0);
        check("early_last_b0", rd_data[0], 32'hA1);
        check("early_last_b1", rd_data[1], 32'hA2);
        // Missing wlast
        wbuf[0] = 32'hB1;
        do_write(4'd6, 32'h208, 8'd0, 3'd2, 2'b01, 4'hF, -1);
        check("no_last_bresp", {30'd0, b_resp}, 32'd2);

        // Reset during the second beat of an 8-beat read
        axi_arid = 4'd7; axi_araddr = 32'h100; axi_arlen = 8'd7; axi_arsize = 3'd2;
        axi_arburst = 2'b01; axi_arvalid = 1'b1;
        wait_hi(3, "arready");
        @(posedge clk); @(negedge clk);
        axi_arvalid = 1'b0; axi_rready = 1'b1;
        wait_hi(4, "rvalid");
        @(posedge clk); @(negedge clk);
        check("mid_rvalid", {31'd0, axi_rvalid}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("async_rvalid", {31'd0, axi_rvalid}, 32'd0);
        check("async_arready", {31'd0, axi_arready}, 32'd0);
        @(negedge clk);
        axi_rready = 1'b0; rst = 1'b1;
        @(negedge clk);
        check("post_rst_arready", {31'd0, axi_arready}, 32'd1);
        do_read(4'd8, 32'h10, 8'd0, 3'd2, 2'b01, -1, 32'd0);
        check("post_rst_rdata", rd_data[0], 32'hDEADBEEF);
        check("post_rst_rid", {28'd0, rd_id}, 32'd8);

        // Write beat and read fetch to 0x40 on the same edge
        write1(32'h40, 32'h0A0A0A0A);
        axi_awid = 4'd1; axi_awaddr = 32'h40; axi_awlen = 8'd0; axi_awsize = 3'd2; axi_awburst = 2'b01;
        axi_arid = 4'd2; axi_araddr = 32'h40; axi_arlen = 8'd0; axi_arsize = 3'd2; axi_arburst = 2'b01;
        check("both_ready", {30'd0, axi_awready, axi_arready}, 32'd3);
        axi_awvalid = 1'b1; axi_arvalid = 1'b1;
        @(posedge clk); @(negedge clk);
        axi_awvalid = 1'b0; axi_arvalid = 1'b0;
        axi_wdata = 32'h5555AAAA; axi_wstrb = 4'hF; axi_wlast = 1'b1; axi_wvalid = 1'b1;
        @(posedge clk); @(negedge clk);
        axi_wvalid = 1'b0; axi_wlast = 1'b0;
        check("ovl_rvalid", {31'd0, axi_rvalid}, 32'd1);
        check("ovl_old_data", axi_rdata, 32'h0A0A0A0A);
        axi_rready = 1'b1;
        @(posedge clk); @(negedge clk);
        axi_rready = 1'b0; axi_bready = 1'b1;
        wait_hi(2, "bvalid");
        check("ovl_bresp", {30'd0, axi_bresp}, 32'd0);
        @(posedge clk); @(negedge clk);
        axi_bready = 1'b0;
        do_read(4'd2, 32'h40, 8'd0, 3'd2, 2'b01, -1, 32'd0);
        check("ovl_new_data", rd_data[0], 32'h5555AAAA);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
